// File: rtl/comms_pkg.sv
// Constants shared by the receive and transmit ends of the inter-board checkers link.
package comms_pkg;

    localparam int FRAME_W     = 256;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_RECV         = 3'd1,
        ST_DONE         = 3'd2,
        ST_ERROR        = 3'd3,
        ST_WAIT_RELEASE = 3'd4
    } link_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, cleared by a synchronous reset.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/board_receiver.sv
// Serial receive end of the inter-board link: oversamples clkIn, shifts in one frame MSB-first
// under the readyForSend/readyForReceive handshake and publishes it with a newData strobe.
//
// state           | meaning
// ST_IDLE         | waiting for remote ready; readyForReceive follows enable
// ST_RECV         | shifting bits on each clkIn rising edge, watching timeout and remote ready
// ST_DONE         | frame complete, receiveBuffer loaded, newData high
// ST_ERROR        | frame aborted, frameError high, receiveBuffer untouched
// ST_WAIT_RELEASE | waiting for the remote to drop readyForSend before re-arming
module board_receiver
    import comms_pkg::*;
#(
    parameter int WIDTH   = FRAME_W,
    parameter int CNT_W   = 9,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TO_W    = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clkIn,
    input  logic             dataIn,
    input  logic             readyForSend,
    output logic             readyForReceive,
    output logic [WIDTH-1:0] receiveBuffer,
    output logic             newData,
    output logic             frameError,
    output logic             busy
);

    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [2:0]       w_sync;
    logic             w_rdy;
    logic             w_clk_s2;
    logic             w_data;
    logic             w_clk_rise;
    logic [WIDTH-1:0] w_shift_next;

    logic             r_clk_s3;
    link_state_t      r_state;
    logic [WIDTH-2:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [TO_W-1:0]  r_to;
    logic             r_rfr;
    logic             r_busy;
    logic             r_new;
    logic             r_err;
    logic [WIDTH-1:0] r_buf;

    sync_2ff #(.W(3)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({readyForSend, clkIn, dataIn}),
        .q   (w_sync)
    );

    assign w_rdy        = w_sync[2];
    assign w_clk_s2     = w_sync[1];
    assign w_data       = w_sync[0];
    assign w_clk_rise   = w_clk_s2 & ~r_clk_s3;
    // Only WIDTH-1 bits are kept; the incoming bit completes the frame on the last edge.
    assign w_shift_next = {r_shift, w_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s3 <= 1'b0;
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_to     <= '0;
            r_rfr    <= 1'b0;
            r_busy   <= 1'b0;
            r_new    <= 1'b0;
            r_err    <= 1'b0;
            r_buf    <= '0;
        end else begin
            r_clk_s3 <= w_clk_s2;
            r_new    <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_rfr  <= enable;
                    r_busy <= 1'b0;
                    if (enable && w_rdy) begin
                        r_state <= ST_RECV;
                        r_cnt   <= '0;
                        r_to    <= '0;
                        r_rfr   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RECV: begin
                    // Losing the remote or timing out wins over a simultaneous clock edge.
                    if (!w_rdy || r_to == TO_MAX) begin
                        r_state <= ST_ERROR;
                        r_err   <= 1'b1;
                        r_rfr   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_clk_rise) begin
                        r_shift <= w_shift_next[WIDTH-2:0];
                        r_cnt   <= r_cnt + 1'b1;
                        r_to    <= '0;
                        if (r_cnt == LAST_BIT) begin
                            r_state <= ST_DONE;
                            r_buf   <= w_shift_next;
                            r_new   <= 1'b1;
                            r_rfr   <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_to != TO_MAX) begin
                        r_to <= r_to + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_WAIT_RELEASE;
                end
                ST_ERROR: begin
                    r_state <= ST_WAIT_RELEASE;
                end
                ST_WAIT_RELEASE: begin
                    r_rfr <= 1'b0;
                    if (!w_rdy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rfr   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign readyForReceive = r_rfr;
    assign receiveBuffer   = r_buf;
    assign newData         = r_new;
    assign frameError      = r_err;
    assign busy            = r_busy;

endmodule

// File: tb/tb_board_receiver.sv
// Scoreboard bench for board_receiver: a 256-bit instance and an 8-bit instance with a short timeout.
module tb_board_receiver;
    import comms_pkg::*;

    localparam int K_BUSY = 0;
    localparam int K_RFR  = 1;
    localparam int K_NEW  = 2;
    localparam int K_ERR  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] en      = '0;
    logic [1:0] clk_in  = '0;
    logic [1:0] data_in = '0;
    logic [1:0] rfs     = '0;
    wire  [1:0] rfr_o;
    wire  [1:0] new_o;
    wire  [1:0] err_o;
    wire  [1:0] busy_o;
    wire  [255:0] buf_big;
    wire  [7:0]   buf_small;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_new[2];
    int n_err[2];
    int t_new[2];
    int t_rise[2];
    logic [255:0] q_big[$];
    logic [255:0] q_small[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    board_receiver #(.WIDTH(256), .CNT_W(9), .TIMEOUT(1024), .TO_W(11)) u_big (
        .clk(clk), .rst(rst), .enable(en[0]), .clkIn(clk_in[0]), .dataIn(data_in[0]),
        .readyForSend(rfs[0]), .readyForReceive(rfr_o[0]), .receiveBuffer(buf_big),
        .newData(new_o[0]), .frameError(err_o[0]), .busy(busy_o[0])
    );

    board_receiver #(.WIDTH(8), .CNT_W(4), .TIMEOUT(16), .TO_W(5)) u_small (
        .clk(clk), .rst(rst), .enable(en[1]), .clkIn(clk_in[1]), .dataIn(data_in[1]),
        .readyForSend(rfs[1]), .readyForReceive(rfr_o[1]), .receiveBuffer(buf_small),
        .newData(new_o[1]), .frameError(err_o[1]), .busy(busy_o[1])
    );

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every newData pops the oldest expected frame of that instance.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (new_o[s] || err_o[s]) chk("strobe_excl", {255'd0, new_o[s] & err_o[s]}, 256'd0);
            if (err_o[s]) n_err[s]++;
            if (new_o[s]) begin
                n_new[s]++;
                t_new[s] = cyc;
                chk("rfr_in_done", {255'd0, rfr_o[s]}, 256'd0);
                if (s == 0) begin
                    if (q_big.size() == 0) chk("unexp_new_big", 256'd1, 256'd0);
                    else chk("buf_big", buf_big, q_big.pop_front());
                end else begin
                    if (q_small.size() == 0) chk("unexp_new_small", 256'd1, 256'd0);
                    else chk("buf_small", {248'd0, buf_small}, q_small.pop_front());
                end
            end
        end
    end

    task automatic send_bit(input int s, input logic b);
        data_in[s] = b;
        repeat (4) @(posedge clk);
        #2 clk_in[s] = 1'b1;
        t_rise[s] = cyc;
        repeat (4) @(posedge clk);
        #2 clk_in[s] = 1'b0;
    endtask

    task automatic send_frame(input int s, input logic [255:0] v, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) send_bit(s, v[i]);
    endtask

    task automatic wait_for(input int s, input int kind, input int budget, input string tag,
                            output int at_cyc);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (kind)
                K_BUSY:  hit = busy_o[s];
                K_RFR:   hit = rfr_o[s];
                K_NEW:   hit = new_o[s];
                default: hit = err_o[s];
            endcase
        end
        at_cyc = cyc;
        chk(tag, {255'd0, hit}, 256'd1);
    endtask

    initial begin
        logic [255:0] tb_frame;
        logic [255:0] rnd;
        int at;
        int base_new;
        int base_err;
        logic any_busy;
        logic any_rfr;

        for (int s = 0; s < 2; s++) begin
            n_new[s] = 0; n_err[s] = 0; t_new[s] = 0; t_rise[s] = 0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rfr",  {254'd0, rfr_o},  256'd0);
        chk("rst_busy", {254'd0, busy_o}, 256'd0);
        chk("rst_new",  {254'd0, new_o},  256'd0);
        chk("rst_err",  {254'd0, err_o},  256'd0);
        chk("rst_buf",  buf_big | {248'd0, buf_small}, 256'd0);
        rst = 1'b0;

        // Disabled: remote ready and clocking, but no local permission.
        rfs[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_bit(1, i[0]);
            chk("dis_rfr",  {255'd0, rfr_o[1]},  256'd0);
            chk("dis_busy", {255'd0, busy_o[1]}, 256'd0);
        end
        chk("dis_strobes", 256'(n_new[1] + n_err[1]), 256'd0);
        rfs[1] = 1'b0;

        // Nominal 256-bit frame.
        en = 2'b11;
        wait_for(0, K_RFR, 10, "nom_rfr_idle", at);
        rfs[0] = 1'b1;
        wait_for(0, K_BUSY, 10, "nom_busy", at);
        tb_frame = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
        q_big.push_back(tb_frame);
        send_frame(0, tb_frame, 256);
        repeat (4) @(posedge clk);
        chk("nom_count", 256'(n_new[0]), 256'd1);
        // two synchronizer flops, one edge-detect cycle consumed by the FSM
        chk("nom_latency", 256'(t_new[0] - t_rise[0]), 256'd3);
        chk("nom_err", 256'(n_err[0]), 256'd0);
        rfs[0] = 1'b0;
        wait_for(0, K_RFR, 10, "nom_rearm", at);

        // Handshake hold on the 8-bit instance.
        base_new = n_new[1];
        rfs[1] = 1'b1;
        wait_for(1, K_BUSY, 10, "hs_busy", at);
        q_small.push_back(256'h0A5);
        send_frame(1, 256'h0A5, 8);
        any_busy = 1'b0;
        any_rfr  = 1'b0;
        repeat (50) begin
            @(negedge clk);
            any_busy |= busy_o[1];
            any_rfr  |= rfr_o[1];
        end
        chk("hs_no_rerun_busy", {255'd0, any_busy}, 256'd0);
        chk("hs_no_rerun_rfr",  {255'd0, any_rfr},  256'd0);
        chk("hs_count", 256'(n_new[1] - base_new), 256'd1);
        @(posedge clk);
        #2 rfs[1] = 1'b0;
        wait_for(1, K_RFR, 6, "hs_rearm", at);
        chk("hs_buf", {248'd0, buf_small}, 256'h0A5);

        // Sender aborts after 4 bits.
        base_new = n_new[1];
        base_err = n_err[1];
        rfs[1] = 1'b1;
        wait_for(1, K_BUSY, 10, "ab_busy", at);
        send_frame(1, 256'h0C, 4);
        rfs[1] = 1'b0;
        wait_for(1, K_ERR, 10, "ab_err_seen", at);
        repeat (5) @(posedge clk);
        chk("ab_err_count", 256'(n_err[1] - base_err), 256'd1);
        chk("ab_no_new", 256'(n_new[1] - base_new), 256'd0);
        chk("ab_buf", {248'd0, buf_small}, 256'h0A5);
        wait_for(1, K_RFR, 10, "ab_rearm", at);

        // Timeout: 3 bits then the remote clock stops with ready held.
        base_new = n_new[1];
        rfs[1] = 1'b1;
        wait_for(1, K_BUSY, 10, "to_busy", at);
        send_frame(1, 256'h5, 3);
        wait_for(1, K_ERR, 40, "to_err_seen", at);
        // 3 cycles to the consuming edge, 16 idle counts, 1 registered abort
        chk("to_latency", 256'(at - t_rise[1]), 256'd20);
        @(negedge clk);
        chk("to_state", 256'(u_small.r_state), 256'(ST_WAIT_RELEASE));
        chk("to_no_new", 256'(n_new[1] - base_new), 256'd0);
        chk("to_buf", {248'd0, buf_small}, 256'h0A5);
        rfs[1] = 1'b0;
        wait_for(1, K_RFR, 10, "to_rearm", at);

        // Reset in the middle of a 256-bit frame.
        rfs[0] = 1'b1;
        wait_for(0, K_BUSY, 10, "mr_busy", at);
        rnd = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
        send_frame(0, rnd, 100);
        base_new = n_new[0];
        base_err = n_err[0];
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mr_buf",  buf_big, 256'd0);
        chk("mr_rfr",  {255'd0, rfr_o[0]},  256'd0);
        chk("mr_busy", {255'd0, busy_o[0]}, 256'd0);
        chk("mr_new",  {255'd0, new_o[0]},  256'd0);
        chk("mr_err",  {255'd0, err_o[0]},  256'd0);
        rst = 1'b0;
        wait_for(0, K_BUSY, 10, "mr_restart", at);
        tb_frame = {8{32'h0303_1010}};
        q_big.push_back(tb_frame);
        send_frame(0, tb_frame, 256);
        repeat (4) @(posedge clk);
        chk("mr_count", 256'(n_new[0] - base_new), 256'd1);
        chk("mr_no_err", 256'(n_err[0] - base_err), 256'd0);
        rfs[0] = 1'b0;
        repeat (10) @(posedge clk);

        chk("sb_big_empty",   256'(q_big.size()),   256'd0);
        chk("sb_small_empty", 256'(q_small.size()), 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
